pkt_wr_fsm: RTL and testbench
=============================

PKT_WR_FSM -- requirements
Module: pkt_wr_fsm

Interface
REQ-001 Parameter: AWIDTH, default 4, write-address width of the downstream address counter; buffer depth is 2**AWIDTH words.
REQ-002 Parameter: DWIDTH, default 8, data word width.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 srst_i  in  1  reset, asynchronous, active-high.
REQ-005 data_i  in  DWIDTH  input stream word.
REQ-006 val_i  in  1  data_i valid.
REQ-007 sop_i  in  1  start of packet; qualified by val_i.
REQ-008 eop_i  in  1  end of packet; qualified by val_i.
REQ-009 ready_o  out  1  block accepts a beat this cycle; a beat is accepted when val_i and ready_o are both high.
REQ-010 rd_done_i  in  1  single-cycle pulse from the reader: the stored packet has been consumed.
REQ-011 wren_o  out  1  write enable to the address counter and memory.
REQ-012 wrdata_o  out  DWIDTH  word to write; valid when wren_o is high.
REQ-013 fsm_clr_o  out  1  single-cycle pulse that clears the downstream write address to 0.
REQ-014 pkt_rdy_o  out  1  a complete packet is stored; held until rd_done_i.
REQ-015 pkt_len_o  out  AWIDTH+1  word count of the stored packet; valid while pkt_rdy_o is high.
REQ-016 err_o  out  1  single-cycle pulse on a dropped packet.

Function
REQ-017 States: IDLE, WRITE, HOLD, DROP.
REQ-018 IDLE: ready_o=1; an accepted beat with sop_i=1 goes to WRITE and counts as word 1; accepted beats without sop_i are discarded.
REQ-019 WRITE: ready_o=1; every accepted beat increments the (AWIDTH+1)-bit word count.
REQ-020 Every word counted in IDLE or WRITE produces wren_o=1 with wrdata_o=data_i exactly one cycle after acceptance (registered outputs); no other cycle asserts wren_o.
REQ-021 An accepted beat with eop_i=1 in WRITE, or with sop_i=1 and eop_i=1 in IDLE, ends the packet: go to HOLD, load pkt_len_o with the final count, and set pkt_rdy_o one cycle after acceptance.
REQ-022 Overflow: an accepted beat in WRITE when the count equals 2**AWIDTH, and the beat does not carry sop_i under REQ-032, writes nothing. fsm_clr_o and err_o each pulse for one cycle one cycle later, and the state goes to DROP.
REQ-023 DROP: ready_o=1; discard all beats up to and including the next beat with eop_i=1, then go to IDLE. No fsm_clr_o pulse on exit.
REQ-024 HOLD: ready_o=0 and pkt_rdy_o=1. When rd_done_i=1, pulse fsm_clr_o one cycle later, clear pkt_rdy_o, set pkt_len_o to 0, and go to IDLE. rd_done_i is ignored in every other state.
REQ-025 The last word's wren_o and the pkt_rdy_o rise occur on the same cycle.
REQ-026 wren_o and fsm_clr_o are never high in the same cycle.
REQ-027 A packet of exactly 2**AWIDTH words ending with eop_i is valid; pkt_len_o then equals 2**AWIDTH.
REQ-028 ready_o is combinational from the state only, never from val_i.

Reset
REQ-029 While srst_i=1: state IDLE; ready_o, wren_o, fsm_clr_o, pkt_rdy_o and err_o are 0; wrdata_o, pkt_len_o and the internal count are 0.
REQ-030 A reset during WRITE, HOLD or DROP abandons the packet with no fsm_clr_o pulse. The downstream address counter shares the reset.
REQ-031 The first beat can be accepted on the first rising edge after srst_i falls.

Configuration
REQ-032 SOP_RESTART_EN defined: an accepted beat with sop_i=1 in WRITE pulses fsm_clr_o one cycle later, restarts the count at 1, and writes that beat as word 1 one cycle after the clear (two cycles after acceptance). Further beats are accepted normally, and their writes are delayed one cycle behind the restart beat's write so the order is preserved.
REQ-033 SOP_RESTART_EN undefined: sop_i in WRITE is ignored, and the beat is treated as an ordinary data word.

Verification
REQ-034 AWIDTH=4: 3-word packet 0x11,0x22,0x33 with sop on the 1st beat and eop on the 3rd -> three wren_o pulses in order, then pkt_rdy_o=1 and pkt_len_o=3. After rd_done_i -> one fsm_clr_o pulse, then IDLE.
REQ-035 16-word packet ending with eop -> 16 writes, pkt_len_o=16, err_o never high.
REQ-036 20-word packet -> 16 writes, then fsm_clr_o and err_o pulse once, beats 17-20 discarded, return to IDLE after the eop beat.
REQ-037 Beats sent while pkt_rdy_o=1 -> ready_o=0 and no wren_o; beats without sop in IDLE -> discarded.
REQ-038 srst_i asserted mid-packet at word 5, with no clock edge -> outputs 0 immediately; the next sop packet is written starting at word 1.
REQ-039 With SOP_RESTART_EN: sop at word 4 of a packet -> fsm_clr_o pulse, then writes restart with that beat; final pkt_len_o counts from the restart.

Source files
------------

// File: rtl/pkt_wr_fsm.sv
// Packet write controller: streams a sop..eop packet into a 2**AWIDTH-word buffer and holds it for the reader.
// Optional macro SOP_RESTART_EN: a sop beat during WRITE restarts the packet instead of being plain data.
module pkt_wr_fsm #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              val_i,
    input  logic              sop_i,
    input  logic              eop_i,
    output logic              ready_o,
    input  logic              rd_done_i,
    output logic              wren_o,
    output logic [DWIDTH-1:0] wrdata_o,
    output logic              fsm_clr_o,
    output logic              pkt_rdy_o,
    output logic [AWIDTH:0]   pkt_len_o,
    output logic              err_o
);

`ifdef SOP_RESTART_EN
    localparam bit RESTART_EN = 1'b1;
`else
    localparam bit RESTART_EN = 1'b0;
`endif

    localparam logic [AWIDTH:0] FULL = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] ONE  = {{AWIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, WRITE, HOLD, DROP} state_t;

    state_t            state, state_nxt;
    logic [AWIDTH:0]   cnt, cnt_nxt;
    logic              wren_nxt, clr_nxt, err_nxt, rdy_nxt;
    logic [DWIDTH-1:0] wrdata_nxt;
    logic [AWIDTH:0]   len_nxt;
    logic              dly, dly_nxt;
    logic              stg_wren, stg_wren_nxt;
    logic [DWIDTH-1:0] stg_data, stg_data_nxt;
    logic              stg_last, stg_last_nxt;
    logic              accept;

    assign ready_o = !srst_i && (state != HOLD);
    assign accept  = val_i && ready_o;

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            cnt       <= '0;
            wren_o    <= 1'b0;
            wrdata_o  <= '0;
            fsm_clr_o <= 1'b0;
            err_o     <= 1'b0;
            pkt_rdy_o <= 1'b0;
            pkt_len_o <= '0;
            dly       <= 1'b0;
            stg_wren  <= 1'b0;
            stg_data  <= '0;
            stg_last  <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            wren_o    <= wren_nxt;
            wrdata_o  <= wrdata_nxt;
            fsm_clr_o <= clr_nxt;
            err_o     <= err_nxt;
            pkt_rdy_o <= rdy_nxt;
            pkt_len_o <= len_nxt;
            dly       <= dly_nxt;
            stg_wren  <= stg_wren_nxt;
            stg_data  <= stg_data_nxt;
            stg_last  <= stg_last_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        wren_nxt     = 1'b0;
        wrdata_nxt   = wrdata_o;
        clr_nxt      = 1'b0;
        err_nxt      = 1'b0;
        rdy_nxt      = pkt_rdy_o;
        len_nxt      = pkt_len_o;
        dly_nxt      = dly;
        stg_wren_nxt = 1'b0;
        stg_data_nxt = stg_data;
        stg_last_nxt = 1'b0;

        // After a restart every write runs one stage late; the last staged word raises pkt_rdy_o with it.
        if (stg_wren) begin
            wren_nxt   = 1'b1;
            wrdata_nxt = stg_data;
            if (stg_last) begin
                rdy_nxt = 1'b1;
                len_nxt = cnt;
                dly_nxt = 1'b0;
            end
        end

        case (state)
            IDLE: begin
                if (accept && sop_i) begin
                    cnt_nxt    = ONE;
                    wren_nxt   = 1'b1;
                    wrdata_nxt = data_i;
                    if (eop_i) begin
                        state_nxt = HOLD;
                        rdy_nxt   = 1'b1;
                        len_nxt   = ONE;
                    end else begin
                        state_nxt = WRITE;
                    end
                end
            end
            WRITE: begin
                if (accept) begin
                    // A clear makes any staged word of the old packet moot, so it is cancelled.
                    if (RESTART_EN && sop_i) begin
                        clr_nxt      = 1'b1;
                        wren_nxt     = 1'b0;
                        cnt_nxt      = ONE;
                        dly_nxt      = 1'b1;
                        stg_wren_nxt = 1'b1;
                        stg_data_nxt = data_i;
                        stg_last_nxt = eop_i;
                        if (eop_i) begin
                            state_nxt = HOLD;
                        end
                    end else if (cnt == FULL) begin
                        clr_nxt   = 1'b1;
                        err_nxt   = 1'b1;
                        wren_nxt  = 1'b0;
                        dly_nxt   = 1'b0;
                        cnt_nxt   = '0;
                        state_nxt = eop_i ? IDLE : DROP;
                    end else begin
                        cnt_nxt = cnt + ONE;
                        if (dly) begin
                            stg_wren_nxt = 1'b1;
                            stg_data_nxt = data_i;
                            stg_last_nxt = eop_i;
                        end else begin
                            wren_nxt   = 1'b1;
                            wrdata_nxt = data_i;
                            if (eop_i) begin
                                rdy_nxt = 1'b1;
                                len_nxt = cnt + ONE;
                            end
                        end
                        if (eop_i) begin
                            state_nxt = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (rd_done_i && pkt_rdy_o) begin
                    clr_nxt   = 1'b1;
                    rdy_nxt   = 1'b0;
                    len_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            DROP: begin
                if (accept && eop_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pkt_wr_fsm.sv
// Scoreboard bench for pkt_wr_fsm: directed packets push expected events, a negedge monitor pops and compares.
module tb_pkt_wr_fsm;

    localparam int AWIDTH = 4;
    localparam int DWIDTH = 8;

    localparam logic [1:0] K_CLR = 2'd0;
    localparam logic [1:0] K_ERR = 2'd1;
    localparam logic [1:0] K_WR  = 2'd2;
    localparam logic [1:0] K_RDY = 2'd3;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] val;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              srst_i = 1'b1;
    logic [DWIDTH-1:0] data_i = '0;
    logic              val_i = 1'b0;
    logic              sop_i = 1'b0;
    logic              eop_i = 1'b0;
    logic              rd_done_i = 1'b0;
    logic              ready_o;
    logic              wren_o;
    logic [DWIDTH-1:0] wrdata_o;
    logic              fsm_clr_o;
    logic              pkt_rdy_o;
    logic [AWIDTH:0]   pkt_len_o;
    logic              err_o;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic rdy_prev = 1'b0;

    pkt_wr_fsm #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
        .clk_i     (clk_i),
        .srst_i    (srst_i),
        .data_i    (data_i),
        .val_i     (val_i),
        .sop_i     (sop_i),
        .eop_i     (eop_i),
        .ready_o   (ready_o),
        .rd_done_i (rd_done_i),
        .wren_o    (wren_o),
        .wrdata_o  (wrdata_o),
        .fsm_clr_o (fsm_clr_o),
        .pkt_rdy_o (pkt_rdy_o),
        .pkt_len_o (pkt_len_o),
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [7:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_compare(input logic [1:0] kind, input logic [7:0] val);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_event: got kind %0d val 0x%0h, expected nothing at %0t", kind, val, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                errors++;
                $display("[TB] FAIL event_order: got kind %0d val 0x%0h, expected kind %0d val 0x%0h at %0t",
                         kind, val, e.kind, e.val, $time);
            end
        end
    endtask

    // Event order within one cycle is clear, error, write, ready; expectations are pushed in that order.
    always @(negedge clk_i) begin
        if (fsm_clr_o && wren_o) begin
            check_output("clr_wren_overlap", 1, 0);
        end
        if (fsm_clr_o) pop_compare(K_CLR, 8'h00);
        if (err_o) pop_compare(K_ERR, 8'h00);
        if (wren_o) pop_compare(K_WR, wrdata_o);
        if (pkt_rdy_o && !rdy_prev) begin
            check_output("rdy_with_last_write", int'(wren_o), 1);
            pop_compare(K_RDY, {3'b000, pkt_len_o});
        end
        rdy_prev = pkt_rdy_o;
    end

    task automatic apply_stimulus(input logic [7:0] d, input logic s, input logic e);
        @(negedge clk_i);
        data_i = d;
        val_i  = 1'b1;
        sop_i  = s;
        eop_i  = e;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            val_i = 1'b0;
            sop_i = 1'b0;
            eop_i = 1'b0;
        end
    endtask

    task automatic pulse_rd_done();
        @(negedge clk_i);
        val_i     = 1'b0;
        rd_done_i = 1'b1;
        @(negedge clk_i);
        rd_done_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk_i);
        check_output("rst_ready", int'(ready_o), 0);
        check_output("rst_wren", int'(wren_o), 0);
        check_output("rst_clr", int'(fsm_clr_o), 0);
        check_output("rst_rdy", int'(pkt_rdy_o), 0);
        check_output("rst_err", int'(err_o), 0);
        check_output("rst_wrdata", int'(wrdata_o), 0);
        check_output("rst_len", int'(pkt_len_o), 0);
        srst_i = 1'b0;
        #1 check_output("ready_after_rst", int'(ready_o), 1);

        // 3-word packet, then beats while held, then release
        push(K_WR, 8'h11); push(K_WR, 8'h22); push(K_WR, 8'h33); push(K_RDY, 8'd3);
        apply_stimulus(8'h11, 1'b1, 1'b0);
        apply_stimulus(8'h22, 1'b0, 1'b0);
        apply_stimulus(8'h33, 1'b0, 1'b1);
        idle_cycles(1);
        check_output("hold_ready", int'(ready_o), 0);
        check_output("hold_len", int'(pkt_len_o), 3);
        apply_stimulus(8'hEE, 1'b1, 1'b1);
        check_output("hold_ready_beat", int'(ready_o), 0);
        apply_stimulus(8'hEF, 1'b0, 1'b0);
        idle_cycles(1);
        push(K_CLR, 8'h00);
        pulse_rd_done();
        idle_cycles(1);
        check_output("release_rdy", int'(pkt_rdy_o), 0);
        check_output("release_len", int'(pkt_len_o), 0);
        check_output("release_ready", int'(ready_o), 1);

        // Beats without sop in IDLE are discarded
        apply_stimulus(8'h99, 1'b0, 1'b0);
        apply_stimulus(8'h98, 1'b0, 1'b1);
        idle_cycles(2);

        // Exactly-full packet
        for (int i = 0; i < 16; i++) push(K_WR, 8'h40 + 8'(i));
        push(K_RDY, 8'd16);
        for (int i = 0; i < 16; i++) apply_stimulus(8'h40 + 8'(i), i == 0, i == 15);
        idle_cycles(2);
        check_output("full_len", int'(pkt_len_o), 16);
        push(K_CLR, 8'h00);
        pulse_rd_done();
        idle_cycles(1);

        // Overflow: 20 words, 16 written, beats 17-20 dropped
        for (int i = 0; i < 16; i++) push(K_WR, 8'h60 + 8'(i));
        push(K_CLR, 8'h00); push(K_ERR, 8'h00);
        for (int i = 0; i < 20; i++) apply_stimulus(8'h60 + 8'(i), i == 0, i == 19);
        idle_cycles(2);
        check_output("drop_rdy", int'(pkt_rdy_o), 0);
        push(K_WR, 8'hC1); push(K_RDY, 8'd1);
        apply_stimulus(8'hC1, 1'b1, 1'b1);
        idle_cycles(2);
        push(K_CLR, 8'h00);
        pulse_rd_done();
        idle_cycles(1);

        // Asynchronous reset mid-packet
        for (int i = 1; i <= 4; i++) push(K_WR, 8'h80 + 8'(i));
        for (int i = 1; i <= 4; i++) apply_stimulus(8'h80 + 8'(i), i == 1, 1'b0);
        apply_stimulus(8'h85, 1'b0, 1'b0);
        #2 srst_i = 1'b1;
        #1 check_output("async_wren", int'(wren_o), 0);
        check_output("async_wrdata", int'(wrdata_o), 0);
        check_output("async_ready", int'(ready_o), 0);
        val_i = 1'b0;
        idle_cycles(1);
        srst_i = 1'b0;
        push(K_WR, 8'hA1); push(K_WR, 8'hA2); push(K_RDY, 8'd2);
        apply_stimulus(8'hA1, 1'b1, 1'b0);
        apply_stimulus(8'hA2, 1'b0, 1'b1);
        idle_cycles(2);
        push(K_CLR, 8'h00);
        pulse_rd_done();
        idle_cycles(1);

        // sop in the middle of a packet
`ifdef SOP_RESTART_EN
        push(K_WR, 8'h51); push(K_WR, 8'h52); push(K_WR, 8'h53);
        push(K_CLR, 8'h00); push(K_WR, 8'h54); push(K_WR, 8'h55); push(K_RDY, 8'd2);
`else
        for (int i = 1; i <= 5; i++) push(K_WR, 8'h50 + 8'(i));
        push(K_RDY, 8'd5);
`endif
        for (int i = 1; i <= 5; i++) apply_stimulus(8'h50 + 8'(i), i == 1 || i == 4, i == 5);
        idle_cycles(3);
        push(K_CLR, 8'h00);
        pulse_rd_done();
        idle_cycles(4);

        check_output("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
